// File: rtl/axi4_lite_regfile_pkg.sv
// Shared definitions for the AXI4-Lite register file: response codes, FSM encodings, width helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  // Word-index width for a memory of 'depth' words, never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/axi4_lite_regfile_mem.sv
// Register storage: DATA_DEPTH words, one byte-enabled synchronous write port, one combinational read port.
// Latency: write lands on the clock edge with wr_en; read data reflects the stored value in the same cycle.
// Backpressure: none; the caller only raises wr_en for in-range words.
//
// Ports:
//   ACLK, ARESETN          clock, async active-low clear of every word
//   wr_en/wr_idx/wr_strb/wr_dat   write port (bytes with wr_strb[k]=1 are updated)
//   rd_idx/rd_dat          read port (pre-write value when a write hits the same word on the same edge)
module axi4_lite_regfile_mem
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 32,
  localparam int IDX_W  = idx_width(DATA_DEPTH),
  localparam int STRB_W = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [STRB_W-1:0]     wr_strb,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_dat
);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < DATA_DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < STRB_W; k++) begin
        if (wr_strb[k]) mem_q[wr_idx][8*k +: 8] <= wr_dat[8*k +: 8];
      end
    end
  end

  assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register file with independent read/write paths, AW/W in any order, byte strobes, SLVERR on out-of-range.
// Latency: BVALID one cycle after the later of the AW/W handshakes; RVALID one cycle after the AR handshake.
// Backpressure: AWREADY/WREADY low while a channel payload is held or a response waits for BREADY; ARREADY low until RREADY.
//
// Ports:
//   ACLK, ARESETN                              clock, async active-low reset
//   S_AXI_AW*, S_AXI_W*, S_AXI_B*              write address / data / response channels
//   S_AXI_AR*, S_AXI_R*                        read address / data channels
module axi4_lite_regfile
  import axi4_lite_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int DATA_DEPTH    = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic [ADDRESS_WIDTH-1:0]  S_AXI_AWADDR,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [ADDRESS_WIDTH-1:0]  S_AXI_ARADDR,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY
);

  localparam int STRB_W     = DATA_WIDTH / 8;
  localparam int ADDR_LSB   = clog2(STRB_W);
  localparam int IDX_FULL_W = ADDRESS_WIDTH - ADDR_LSB;
  localparam int IDX_W      = idx_width(DATA_DEPTH);
  localparam logic [IDX_FULL_W-1:0] DEPTH_LIM = IDX_FULL_W'(DATA_DEPTH);

  // Sub-word address bits carry no meaning here; misaligned accesses hit the containing word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // ---------------- write path ----------------
  wr_state_t              w_state;
  logic                   aw_held, w_held;
  logic [IDX_FULL_W-1:0]  aw_idx_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [STRB_W-1:0]      wstrb_q;
  logic                   bvalid_q;
  logic [1:0]             bresp_q;

  logic                   aw_hs, w_hs, wr_commit, wr_in_range;
  logic [IDX_FULL_W-1:0]  aw_idx_in, wr_idx_full;
  logic [DATA_WIDTH-1:0]  wr_dat;
  logic [STRB_W-1:0]      wr_strb;

  assign S_AXI_AWREADY = (w_state == W_IDLE) && !aw_held;
  assign S_AXI_WREADY  = (w_state == W_IDLE) && !w_held;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;

  assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs      = S_AXI_WVALID && S_AXI_WREADY;
  assign aw_idx_in = S_AXI_AWADDR[ADDRESS_WIDTH-1:ADDR_LSB];

  // A payload completing this cycle bypasses its holding register so the
  // commit can happen on the same edge as the last handshake.
  assign wr_idx_full = aw_hs ? aw_idx_in : aw_idx_q;
  assign wr_dat      = w_hs ? S_AXI_WDATA : wdata_q;
  assign wr_strb     = w_hs ? S_AXI_WSTRB : wstrb_q;
  assign wr_commit   = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_in_range = wr_idx_full < DEPTH_LIM;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state  <= W_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (wr_commit) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            w_state  <= W_RESP;
          end else begin
            if (aw_hs) begin
              aw_held  <= 1'b1;
              aw_idx_q <= aw_idx_in;
            end
            if (w_hs) begin
              w_held  <= 1'b1;
              wdata_q <= S_AXI_WDATA;
              wstrb_q <= S_AXI_WSTRB;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_q <= 1'b0;
            w_state  <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  rd_state_t              r_state;
  logic                   rvalid_q;
  logic [1:0]             rresp_q;
  logic [DATA_WIDTH-1:0]  rdata_q;

  logic [IDX_FULL_W-1:0]  ar_idx;
  logic                   rd_in_range;
  logic [DATA_WIDTH-1:0]  mem_rd_dat;

  assign S_AXI_ARREADY = (r_state == R_IDLE);
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;

  assign ar_idx      = S_AXI_ARADDR[ADDRESS_WIDTH-1:ADDR_LSB];
  assign rd_in_range = ar_idx < DEPTH_LIM;

  // The memory read is sampled on the same edge a colliding write lands,
  // so a simultaneous AR sees the pre-write contents.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state  <= R_IDLE;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (S_AXI_ARVALID) begin
            rdata_q  <= rd_in_range ? mem_rd_dat : '0;
            rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
            rvalid_q <= 1'b1;
            r_state  <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
            r_state  <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- storage ----------------
  axi4_lite_regfile_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DATA_DEPTH (DATA_DEPTH)
  ) u_mem (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .wr_en   (wr_commit && wr_in_range),
    .wr_idx  (wr_idx_full[IDX_W-1:0]),
    .wr_strb (wr_strb),
    .wr_dat  (wr_dat),
    .rd_idx  (ar_idx[IDX_W-1:0]),
    .rd_dat  (mem_rd_dat)
  );

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed bench for axi4_lite_regfile: handshakes, strobes, range errors, read/write collision, mid-transaction reset.
// The DUT address port is 16 bits wide: region-select bits above that are consumed by the interconnect,
// so a system address such as 0x1000_0004 arrives here as 0x0004.
module tb_axi4_lite_regfile;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [AW-1:0] S_AXI_AWADDR = '0;
  logic          S_AXI_AWVALID = 1'b0;
  logic          S_AXI_AWREADY;
  logic [DW-1:0] S_AXI_WDATA = '0;
  logic [3:0]    S_AXI_WSTRB = '0;
  logic          S_AXI_WVALID = 1'b0;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY = 1'b1;
  logic [AW-1:0] S_AXI_ARADDR = '0;
  logic          S_AXI_ARVALID = 1'b0;
  logic          S_AXI_ARREADY;
  logic [DW-1:0] S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [31:0] shadow [DEPTH];

  always #5 ACLK = ~ACLK;

  axi4_lite_regfile #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .DATA_DEPTH    (DEPTH)
  ) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY)
  );

  // Full write with AW and W presented together; lat counts extra cycles before BVALID.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          output logic [1:0] resp, output int lat);
    bit aw_done, w_done;
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR = addr[AW-1:0]; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 20) begin
      bit aw_go, w_go;
      aw_go = S_AXI_AWVALID && S_AXI_AWREADY;
      w_go  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK); @(negedge ACLK);
      if (aw_go) begin aw_done = 1; S_AXI_AWVALID = 1'b0; end
      if (w_go)  begin w_done = 1;  S_AXI_WVALID = 1'b0; end
      n++;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    resp = 2'bxx; lat = -1;
    if (!(aw_done && w_done)) begin
      checks++; errors++;
      $display("FAIL write_handshake_timeout addr=%h got no AW/W handshake, required within 20 cycles", addr);
    end else begin
      lat = 0;
      while (!S_AXI_BVALID && lat < 20) begin @(posedge ACLK); @(negedge ACLK); lat++; end
      resp = S_AXI_BRESP;
      if (!S_AXI_BVALID) begin
        checks++; errors++;
        $display("FAIL write_bvalid_timeout addr=%h got BVALID=0, required BVALID=1 within 20 cycles", addr);
      end else begin
        @(posedge ACLK); @(negedge ACLK);
      end
    end
  endtask

  // Full read; lat counts extra cycles before RVALID.
  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                         output int lat);
    bit done;
    int n;
    @(negedge ACLK);
    S_AXI_ARADDR = addr[AW-1:0]; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
    done = 0; n = 0;
    while (!done && n < 20) begin
      bit go;
      go = S_AXI_ARREADY;
      @(posedge ACLK); @(negedge ACLK);
      if (go) done = 1;
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    data = 'x; resp = 2'bxx; lat = -1;
    if (!done) begin
      checks++; errors++;
      $display("FAIL read_handshake_timeout addr=%h got no AR handshake, required within 20 cycles", addr);
    end else begin
      lat = 0;
      while (!S_AXI_RVALID && lat < 20) begin @(posedge ACLK); @(negedge ACLK); lat++; end
      data = S_AXI_RDATA; resp = S_AXI_RRESP;
      if (!S_AXI_RVALID) begin
        checks++; errors++;
        $display("FAIL read_rvalid_timeout addr=%h got RVALID=0, required RVALID=1 within 20 cycles", addr);
      end else begin
        @(posedge ACLK); @(negedge ACLK);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    checks++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin errors++;
      $display("FAIL reset_readies got AW/W/AR=%b required 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
    checks++; if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b00) begin errors++;
      $display("FAIL reset_valids got B/R=%b required 00", {S_AXI_BVALID, S_AXI_RVALID}); end
    checks++; if ({S_AXI_BRESP, S_AXI_RRESP} !== 4'b0000) begin errors++;
      $display("FAIL reset_resps got BRESP/RRESP=%b required 0000", {S_AXI_BRESP, S_AXI_RRESP}); end
    checks++; if (S_AXI_RDATA !== 32'h0) begin errors++;
      $display("FAIL reset_rdata got %h required 00000000", S_AXI_RDATA); end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h1000_0004, 32'hDEAD_BEEF, 4'hF, r, lat);
    shadow[1] = 32'hDEAD_BEEF;
    checks++; if (r !== 2'b00 || lat !== 0) begin errors++;
      $display("FAIL basic_write got bresp=%b lat=%0d required bresp=00 lat=0", r, lat); end
    do_read(32'h0000_0004, d, r, lat);
    checks++; if (d !== 32'hDEAD_BEEF || r !== 2'b00 || lat !== 0) begin errors++;
      $display("FAIL basic_read got %h/%b lat=%0d required deadbeef/00 lat=0", d, r, lat); end
  endtask

  task automatic test_w_first();
    logic [31:0] d; logic [1:0] r; int lat;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b0;
    S_AXI_WDATA = 32'h0BAD_F00D; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    checks++; if ({S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID} !== 3'b010) begin errors++;
      $display("FAIL wfirst_held got WREADY/AWREADY/BVALID=%b required 010",
               {S_AXI_WREADY, S_AXI_AWREADY, S_AXI_BVALID}); end
    repeat (2) @(negedge ACLK);
    S_AXI_AWADDR = 16'h000C; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    // A second full write is offered while the first response is stalled.
    S_AXI_AWADDR = 16'h0010; S_AXI_WDATA = 32'hFFFF_FFFF; S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY} !== 5'b10000) begin errors++;
        $display("FAIL wfirst_stall_cyc%0d got BVALID/BRESP/AWREADY/WREADY=%b required 10000", i,
                 {S_AXI_BVALID, S_AXI_BRESP, S_AXI_AWREADY, S_AXI_WREADY}); end
      @(posedge ACLK); @(negedge ACLK);
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    checks++; if ({S_AXI_BVALID, S_AXI_AWREADY} !== 2'b01) begin errors++;
      $display("FAIL wfirst_release got BVALID/AWREADY=%b required 01", {S_AXI_BVALID, S_AXI_AWREADY}); end
    shadow[3] = 32'h0BAD_F00D;
    do_read(32'h0C, d, r, lat);
    checks++; if (d !== 32'h0BAD_F00D || r !== 2'b00) begin errors++;
      $display("FAIL wfirst_word3 got %h/%b required 0badf00d/00", d, r); end
    do_read(32'h10, d, r, lat);
    checks++; if (d !== 32'h0) begin errors++;
      $display("FAIL wfirst_word4_untouched got %h required 00000000", d); end
  endtask

  task automatic test_wstrb();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h08, 32'h1122_3344, 4'hF, r, lat);
    do_write(32'h08, 32'hAABB_CCDD, 4'b0101, r, lat);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL wstrb_bresp got %b required 00", r); end
    do_read(32'h08, d, r, lat);
    checks++; if (d !== 32'h11BB_33DD) begin errors++; $display("FAIL wstrb_merge got %h required 11bb33dd", d); end
    do_write(32'h08, 32'hFFFF_FFFF, 4'h0, r, lat);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL wstrb_zero_bresp got %b required 00", r); end
    do_read(32'h08, d, r, lat);
    checks++; if (d !== 32'h11BB_33DD) begin errors++; $display("FAIL wstrb_zero_noop got %h required 11bb33dd", d); end
    shadow[2] = 32'h11BB_33DD;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r; int lat;
    @(negedge ACLK);
    S_AXI_BREADY = 1'b1;
    S_AXI_AWADDR = 16'h0018; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h6060_6060; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    checks++; if ({S_AXI_BVALID, S_AXI_AWREADY} !== 2'b10) begin errors++;
      $display("FAIL b2b_first_resp got BVALID/AWREADY=%b required 10", {S_AXI_BVALID, S_AXI_AWREADY}); end
    S_AXI_AWADDR = 16'h001C; S_AXI_WDATA = 32'h7070_7070;
    @(posedge ACLK); @(negedge ACLK);
    checks++; if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b011) begin errors++;
      $display("FAIL b2b_idle got BVALID/AWREADY/WREADY=%b required 011",
               {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}); end
    @(posedge ACLK); @(negedge ACLK);
    checks++; if (S_AXI_BVALID !== 1'b1) begin errors++;
      $display("FAIL b2b_second_resp got BVALID=%b required 1", S_AXI_BVALID); end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    shadow[6] = 32'h6060_6060; shadow[7] = 32'h7070_7070;
    do_read(32'h18, d, r, lat);
    checks++; if (d !== 32'h6060_6060) begin errors++; $display("FAIL b2b_word6 got %h required 60606060", d); end
    do_read(32'h1C, d, r, lat);
    checks++; if (d !== 32'h7070_7070) begin errors++; $display("FAIL b2b_word7 got %h required 70707070", d); end
  endtask

  task automatic test_collision();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h14, 32'h1, 4'hF, r, lat);
    @(negedge ACLK);
    checks++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin errors++;
      $display("FAIL coll_ready got %b required 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
    S_AXI_AWADDR = 16'h0014; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'h2; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    S_AXI_ARADDR = 16'h0014; S_AXI_ARVALID = 1'b1;
    S_AXI_BREADY = 1'b1; S_AXI_RREADY = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    checks++; if ({S_AXI_RVALID, S_AXI_BVALID} !== 2'b11 || S_AXI_RDATA !== 32'h1) begin errors++;
      $display("FAIL coll_old_value got RVALID/BVALID=%b rdata=%h required 11 rdata=00000001",
               {S_AXI_RVALID, S_AXI_BVALID}, S_AXI_RDATA); end
    @(posedge ACLK); @(negedge ACLK);
    shadow[5] = 32'h2;
    do_read(32'h14, d, r, lat);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL coll_new_value got %h required 00000002", d); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int lat;
    do_write(32'h80, 32'h5A5A_5A5A, 4'hF, r, lat);
    checks++; if (r !== 2'b10) begin errors++; $display("FAIL oor_write_bresp got %b required 10", r); end
    do_read(32'h80, d, r, lat);
    checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++;
      $display("FAIL oor_read got %h/%b required 00000000/10", d, r); end
    do_read(32'hFFFC, d, r, lat);
    checks++; if (d !== 32'h0 || r !== 2'b10) begin errors++;
      $display("FAIL oor_read_top got %h/%b required 00000000/10", d, r); end
    // Last word through a misaligned address: low bits are ignored.
    do_write(32'h7F, 32'h3131_3131, 4'hF, r, lat);
    checks++; if (r !== 2'b00) begin errors++; $display("FAIL last_word_bresp got %b required 00", r); end
    shadow[31] = 32'h3131_3131;
    for (int i = 0; i < DEPTH; i++) begin
      do_read(32'(i * 4), d, r, lat);
      checks++; if (d !== shadow[i] || r !== 2'b00) begin errors++;
        $display("FAIL sweep_word%0d got %h/%b required %h/00", i, d, r, shadow[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r; int lat;
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0; S_AXI_ARADDR = 16'h0004; S_AXI_ARVALID = 1'b1;
    S_AXI_WDATA = 32'h8888_8888; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_ARVALID = 1'b0; S_AXI_WVALID = 1'b0;
    checks++; if ({S_AXI_RVALID, S_AXI_WREADY} !== 2'b10) begin errors++;
      $display("FAIL rst_mid_setup got RVALID/WREADY=%b required 10", {S_AXI_RVALID, S_AXI_WREADY}); end
    #2 ARESETN = 1'b0;
    #1;
    checks++; if ({S_AXI_RVALID, S_AXI_BVALID} !== 2'b00) begin errors++;
      $display("FAIL rst_mid_async got RVALID/BVALID=%b required 00", {S_AXI_RVALID, S_AXI_BVALID}); end
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1; S_AXI_RREADY = 1'b1;
    for (int i = 0; i < DEPTH; i++) shadow[i] = 32'h0;
    @(negedge ACLK);
    checks++; if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin errors++;
      $display("FAIL rst_mid_readies got %b required 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}); end
    // AW alone must wait for fresh W data: the pre-reset W was discarded.
    S_AXI_AWADDR = 16'h0024; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    @(posedge ACLK); @(negedge ACLK);
    checks++; if ({S_AXI_BVALID, S_AXI_WREADY} !== 2'b01) begin errors++;
      $display("FAIL rst_mid_aw_waits got BVALID/WREADY=%b required 01", {S_AXI_BVALID, S_AXI_WREADY}); end
    S_AXI_WDATA = 32'h99; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); @(negedge ACLK);
    S_AXI_WVALID = 1'b0;
    checks++; if ({S_AXI_BVALID, S_AXI_BRESP} !== 3'b100) begin errors++;
      $display("FAIL rst_mid_commit got BVALID/BRESP=%b required 100", {S_AXI_BVALID, S_AXI_BRESP}); end
    @(posedge ACLK); @(negedge ACLK);
    shadow[9] = 32'h99;
    for (int i = 0; i < DEPTH; i++) begin
      do_read(32'(i * 4), d, r, lat);
      checks++; if (d !== shadow[i]) begin errors++;
        $display("FAIL rst_sweep_word%0d got %h required %h", i, d, shadow[i]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = 32'h0;
    test_reset();
    test_basic();
    test_w_first();
    test_wstrb();
    test_back_to_back();
    test_collision();
    test_out_of_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
